outpkt_cmp_result: RTL

Output packet builder for comparator results (application type 0x82). Accepts one result record (gen_id, word_id, pkt_id, hash_num) from the comparator-to-CLK crossing FIFO and serializes it as a 16-bit word stream: a 10-byte header followed by an 8-byte body. It sits in pkt_comm's output path directly upstream of outpkt_checksum, using the same dout/pkt_new/pkt_end/rd_en/empty stream interface as outpkt_word.

---
 rtl/pkt_comm_pkg.sv | 43 ++++
 rtl/outpkt_cmp_result.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pkt_comm_pkg.sv
// Shared constants for the pkt_comm output packet builders.
// Header layout (16-bit words, low byte first on the wire):
//   word 0: {type, version}   word 1: reserved
//   word 2: length[15:0]      word 3: {reserved, length[23:16]}
//   word 4: input packet id
package pkt_comm_pkg;

  localparam logic [7:0] OUTPKT_TYPE_CMP_RESULT = 8'h82;
  localparam int         OUTPKT_HEADER_WORDS    = 5;
  localparam int         CMP_RESULT_BODY_BYTES  = 8;

  // Header word indices, shared with outpkt_word
  localparam logic [3:0] HDR_IDX_TYPE_VER = 4'd0;
  localparam logic [3:0] HDR_IDX_RSVD     = 4'd1;
  localparam logic [3:0] HDR_IDX_LEN_LO   = 4'd2;
  localparam logic [3:0] HDR_IDX_LEN_HI   = 4'd3;
  localparam logic [3:0] HDR_IDX_PKT_ID   = 4'd4;

  // Comparator-result body word indices
  localparam logic [3:0] CMP_IDX_WORD_ID  = 4'd5;
  localparam logic [3:0] CMP_IDX_GEN_LO   = 4'd6;
  localparam logic [3:0] CMP_IDX_GEN_HI   = 4'd7;
  localparam logic [3:0] CMP_IDX_HASH_NUM = 4'd8;

  // Index of the final word in a comparator-result packet
  localparam logic [3:0] CMP_RESULT_LAST_IDX =
    4'(OUTPKT_HEADER_WORDS + (CMP_RESULT_BODY_BYTES / 2) - 1);

  // Body length as carried in the header (upper length byte is always 0 here)
  localparam logic [15:0] CMP_RESULT_LEN_LO = 16'(CMP_RESULT_BODY_BYTES);

  typedef enum logic [0:0] {
    CMP_ST_IDLE = 1'b0,
    CMP_ST_SEND = 1'b1
  } cmp_result_state_e;

  // Header word 0: type in the high byte so the version goes out first
  function automatic logic [15:0] hdr_word0(input logic [7:0] pkt_type,
                                            input logic [7:0] version);
    return {pkt_type, version};
  endfunction

endpackage

// File: rtl/outpkt_cmp_result.sv
// Output packet builder for comparator results. Holds one result record and
// serializes it as a 5-word header plus 4-word body on the dout stream.
// dout/pkt_new/pkt_end depend only on registered state, never on inputs.
module outpkt_cmp_result
  import pkt_comm_pkg::*;
#(
  parameter int         VERSION  = 1,
  parameter logic [7:0] PKT_TYPE = OUTPKT_TYPE_CMP_RESULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] gen_id,
  input  logic [15:0] word_id,
  input  logic [15:0] pkt_id,
  input  logic [15:0] hash_num,
  input  logic        wr_en,
  output logic        full,
  output logic [15:0] dout,
  output logic        pkt_new,
  output logic        pkt_end,
  input  logic        rd_en,
  output logic        empty,
  output logic        err_overflow
);

  localparam logic [7:0] VERSION_BYTE = VERSION[7:0];

  cmp_result_state_e state_r;
  cmp_result_state_e state_s;
  logic [3:0]        idx_r;
  logic [3:0]        idx_s;
  logic              load_s;
  logic              full_r;
  logic              empty_r;
  logic              err_overflow_r;
  logic [31:0]       gen_id_r;
  logic [15:0]       word_id_r;
  logic [15:0]       pkt_id_r;
  logic [15:0]       hash_num_r;
  logic [15:0]       dout_s;

  // Next-state and word index: accept a record in IDLE, step idx on each read in SEND
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    load_s  = 1'b0;
    case (state_r)
      CMP_ST_IDLE: begin
        if (wr_en) begin
          state_s = CMP_ST_SEND;
          idx_s   = 4'd0;
          load_s  = 1'b1;
        end else begin
          state_s = CMP_ST_IDLE;
          idx_s   = 4'd0;
        end
      end
      CMP_ST_SEND: begin
        if (rd_en) begin
          if (idx_r == CMP_RESULT_LAST_IDX) begin
            state_s = CMP_ST_IDLE;
            idx_s   = 4'd0;
          end else begin
            idx_s   = idx_r + 4'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      default: begin
        state_s = CMP_ST_IDLE;
        idx_s   = 4'd0;
      end
    endcase
  end

  // State, index and the registered full/empty flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= CMP_ST_IDLE;
      idx_r   <= 4'd0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      full_r  <= (state_s == CMP_ST_SEND);
      empty_r <= (state_s != CMP_ST_SEND);
    end
  end

  // Sticky overflow: any write attempted while the record buffer is occupied
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_overflow_r <= 1'b0;
    end else if (wr_en && full_r) begin
      err_overflow_r <= 1'b1;
    end else begin
      err_overflow_r <= err_overflow_r;
    end
  end

  // Record buffer: captured only on an accepted write, untouched by dropped writes
  always_ff @(posedge CLK) begin
    if (RST) begin
      gen_id_r   <= 32'h0000_0000;
      word_id_r  <= 16'h0000;
      pkt_id_r   <= 16'h0000;
      hash_num_r <= 16'h0000;
    end else if (load_s) begin
      gen_id_r   <= gen_id;
      word_id_r  <= word_id;
      pkt_id_r   <= pkt_id;
      hash_num_r <= hash_num;
    end else begin
      gen_id_r   <= gen_id_r;
      word_id_r  <= word_id_r;
      pkt_id_r   <= pkt_id_r;
      hash_num_r <= hash_num_r;
    end
  end

  // Output word mux; drives zero whenever no packet is being sent
  always_comb begin
    dout_s = 16'h0000;
    if (state_r == CMP_ST_SEND) begin
      case (idx_r)
        HDR_IDX_TYPE_VER: dout_s = hdr_word0(PKT_TYPE, VERSION_BYTE);
        HDR_IDX_RSVD:     dout_s = 16'h0000;
        HDR_IDX_LEN_LO:   dout_s = CMP_RESULT_LEN_LO;
        HDR_IDX_LEN_HI:   dout_s = 16'h0000;
        HDR_IDX_PKT_ID:   dout_s = pkt_id_r;
        CMP_IDX_WORD_ID:  dout_s = word_id_r;
        CMP_IDX_GEN_LO:   dout_s = gen_id_r[15:0];
        CMP_IDX_GEN_HI:   dout_s = gen_id_r[31:16];
        CMP_IDX_HASH_NUM: dout_s = hash_num_r;
        default:          dout_s = 16'h0000;
      endcase
    end else begin
      dout_s = 16'h0000;
    end
  end

  assign dout         = dout_s;
  assign pkt_new      = full_r && (idx_r == HDR_IDX_TYPE_VER);
  assign pkt_end      = full_r && (idx_r == CMP_RESULT_LAST_IDX);
  assign full         = full_r;
  assign empty        = empty_r;
  assign err_overflow = err_overflow_r;

endmodule
